// File: rtl/rr_hold_arbiter.sv
// rtl/rr_hold_arbiter.sv - registered round-robin arbiter with grant hold and burst limit
//
// Shares one resource between ISIZE requesters. A granted requester keeps the
// grant while it holds its request; under contention it is limited to MAX_HOLD
// consecutive cycles. A rotating priority pointer provides fairness.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   reqs       request vector, bit i = requester i wants the resource
//   gnts       registered one-hot grant vector, zero when idle
//   gnt_valid  high when any grant is asserted (|gnts)
//   gnt_id     binary index of the granted requester, zero when idle

module rr_hold_arbiter #(
    parameter int ISIZE    = 8,
    parameter int MAX_HOLD = 4,
    parameter int IDW      = $clog2(ISIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ISIZE-1:0] reqs,
    output logic [ISIZE-1:0] gnts,
    output logic             gnt_valid,
    output logic [IDW-1:0]   gnt_id
);

    localparam int HCW = (MAX_HOLD + 1 > 1) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [IDW-1:0]   ptr, ptr_n;
    logic [IDW-1:0]   owner, owner_n;
    logic [HCW-1:0]   hold_cnt, hold_cnt_n;
    logic [ISIZE-1:0] gnts_n;
    logic             gnt_valid_n;

    logic [ISIZE-1:0] owner_onehot;
    logic [ISIZE-1:0] others;
    logic             release_now;
    logic             preempt_now;
    logic [IDW-1:0]   ptr_after;

    // First set bit of cand, searching start, start+1, ..., wrapping modulo ISIZE.
    function automatic logic [IDW-1:0] pick(input logic [ISIZE-1:0] cand,
                                            input logic [IDW-1:0]   start);
        logic [IDW-1:0] result;
        logic           found;
        int             idx;
        result = '0;
        found  = 1'b0;
        for (int i = 0; i < ISIZE; i++) begin
            idx = (int'(start) + i) % ISIZE;
            if (!found && cand[idx]) begin
                result = IDW'(idx);
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    function automatic logic [ISIZE-1:0] onehot(input logic [IDW-1:0] idx);
        logic [ISIZE-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Decode of the current owner's situation; only meaningful in GRANT.
    always_comb begin
        owner_onehot = onehot(owner);
        others       = reqs & ~owner_onehot;
        release_now  = ~reqs[owner];
        // A saturated hold counter means the burst is used up; the first
        // competing request at or after that point takes the resource.
        preempt_now  = reqs[owner] && (hold_cnt == HOLD_LAST) && (|others);
        ptr_after    = (int'(owner) == ISIZE - 1) ? '0 : owner + 1'b1;
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        owner_n     = owner;
        hold_cnt_n  = hold_cnt;
        gnts_n      = gnts;
        gnt_valid_n = gnt_valid;

        unique case (state)
            IDLE: begin
                if (|reqs) begin
                    owner_n     = pick(reqs, ptr);
                    gnts_n      = onehot(owner_n);
                    gnt_valid_n = 1'b1;
                    hold_cnt_n  = '0;
                    state_n     = GRANT;
                end
            end

            GRANT: begin
                if (release_now || preempt_now) begin
                    ptr_n = ptr_after;
                    if (|others) begin
                        // Hand over at this edge so there is no idle bubble.
                        owner_n     = pick(others, ptr_after);
                        gnts_n      = onehot(owner_n);
                        gnt_valid_n = 1'b1;
                        hold_cnt_n  = '0;
                    end else begin
                        owner_n     = '0;
                        gnts_n      = '0;
                        gnt_valid_n = 1'b0;
                        hold_cnt_n  = '0;
                        state_n     = IDLE;
                    end
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end

            default: begin
                state_n     = IDLE;
                owner_n     = '0;
                gnts_n      = '0;
                gnt_valid_n = 1'b0;
                hold_cnt_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            hold_cnt  <= '0;
            gnts      <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            owner     <= owner_n;
            hold_cnt  <= hold_cnt_n;
            gnts      <= gnts_n;
            gnt_valid <= gnt_valid_n;
        end
    end

    // owner is a register cleared on return to IDLE, so it is the grant index.
    assign gnt_id = owner;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// tb/tb_rr_hold_arbiter.sv - directed self-checking bench for rr_hold_arbiter

module tb_rr_hold_arbiter;

    localparam int ISIZE = 8;
    localparam int IDW   = 3;

    logic             clk;
    logic             rst_n;
    logic [ISIZE-1:0] reqs;
    logic [ISIZE-1:0] gnts;
    logic             gnt_valid;
    logic [IDW-1:0]   gnt_id;

    int errors = 0;
    int checks = 0;

    rr_hold_arbiter #(.ISIZE(ISIZE), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reqs      (reqs),
        .gnts      (gnts),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        reqs  = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            if (gnts !== 8'h00) begin
                errors++;
                $display("FAIL reset_gnts cycle %0d: got %h want 00", c, gnts);
            end
            checks++;
            if (gnt_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid cycle %0d: got %b want 0", c, gnt_valid);
            end
            checks++;
            if (gnt_id !== 3'd0) begin
                errors++;
                $display("FAIL reset_id cycle %0d: got %0d want 0", c, gnt_id);
            end
            checks++;
        end
    endtask

    task automatic test_rotation();
        logic [7:0] exp_g;
        logic [2:0] exp_id;
        do_reset();
        reqs = 8'h1F;
        for (int c = 0; c < 24; c++) begin
            tick();
            exp_id = 3'((c / 4) % 5);
            exp_g  = 8'h01 << exp_id;
            if (gnts !== exp_g) begin
                errors++;
                $display("FAIL rotation_gnts cycle %0d: got %h want %h", c, gnts, exp_g);
            end
            checks++;
            if (gnt_id !== exp_id || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL rotation_id cycle %0d: got id %0d valid %b want id %0d valid 1",
                         c, gnt_id, gnt_valid, exp_id);
            end
            checks++;
        end
    endtask

    task automatic test_release();
        do_reset();
        reqs = 8'h3A;
        tick();
        if (gnts !== 8'h02 || gnt_id !== 3'd1) begin
            errors++;
            $display("FAIL release_first: got %h id %0d want 02 id 1", gnts, gnt_id);
        end
        checks++;
        reqs = 8'h38;
        tick();
        if (gnts !== 8'h08 || gnt_id !== 3'd3) begin
            errors++;
            $display("FAIL release_next: got %h id %0d want 08 id 3", gnts, gnt_id);
        end
        checks++;
    endtask

    task automatic test_no_contention();
        do_reset();
        reqs = 8'h04;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (gnts !== 8'h04 || gnt_id !== 3'd2) begin
                errors++;
                $display("FAIL hold_alone cycle %0d: got %h id %0d want 04 id 2", c, gnts, gnt_id);
            end
            checks++;
        end
        reqs = 8'h0C;
        tick();
        if (gnts !== 8'h08 || gnt_id !== 3'd3) begin
            errors++;
            $display("FAIL preempt_saturated: got %h id %0d want 08 id 3", gnts, gnt_id);
        end
        checks++;
        // Owner 3 now holds; requester 2 waits. With ptr at 3, release of 3
        // must go to 2 by wrapping all the way around.
        reqs = 8'h04;
        tick();
        if (gnts !== 8'h04) begin
            errors++;
            $display("FAIL after_preempt: got %h want 04", gnts);
        end
        checks++;
    endtask

    task automatic test_wrap();
        do_reset();
        reqs = 8'h40;
        tick();
        if (gnts !== 8'h40) begin
            errors++;
            $display("FAIL wrap_setup: got %h want 40", gnts);
        end
        checks++;
        reqs = 8'h81;
        tick();
        if (gnts !== 8'h80 || gnt_id !== 3'd7) begin
            errors++;
            $display("FAIL wrap_top: got %h id %0d want 80 id 7", gnts, gnt_id);
        end
        checks++;
        reqs = 8'h01;
        tick();
        if (gnts !== 8'h01 || gnt_id !== 3'd0) begin
            errors++;
            $display("FAIL wrap_around: got %h id %0d want 01 id 0", gnts, gnt_id);
        end
        checks++;
        reqs = 8'h00;
        tick();
        if (gnts !== 8'h00 || gnt_valid !== 1'b0 || gnt_id !== 3'd0) begin
            errors++;
            $display("FAIL wrap_idle: got %h valid %b id %0d want 00 0 0", gnts, gnt_valid, gnt_id);
        end
        checks++;
    endtask

    task automatic test_async_reset();
        do_reset();
        reqs = 8'h10;
        tick();
        if (gnts !== 8'h10) begin
            errors++;
            $display("FAIL async_setup: got %h want 10", gnts);
        end
        checks++;
        #2;
        rst_n = 1'b0;
        #1;
        if (gnts !== 8'h00 || gnt_valid !== 1'b0 || gnt_id !== 3'd0) begin
            errors++;
            $display("FAIL async_drop: got %h valid %b id %0d want 00 0 0", gnts, gnt_valid, gnt_id);
        end
        checks++;
        reqs = 8'h0A;
        tick();
        rst_n = 1'b1;
        tick();
        if (gnts !== 8'h02 || gnt_id !== 3'd1) begin
            errors++;
            $display("FAIL async_restart: got %h id %0d want 02 id 1", gnts, gnt_id);
        end
        checks++;
    endtask

    initial begin
        rst_n = 1'b0;
        reqs  = '0;
        test_reset();
        test_rotation();
        test_release();
        test_no_contention();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
